issue_order_ctrl: RTL

//  N-wide issue-slot ordering controller in EX, between the ID/EX register and the ALU/MUL-DIV units.
//  - Squashes younger slots behind an older load/store or branch.
//  - NOPs slot 0 in the cycle after an EX forwarding stall.
//  - Steers M-ops (op >= ALU_MUL_BASE) to the single shared MUL/DIV unit.
//  - Parks surplus M-ops in an in-order replay FIFO.

---
 rtl/issue_order_if.sv | 16 +
 rtl/issue_order_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/issue_order_if.sv
// MUL/DIV issue handshake: valid/ready with opcode, operands and destination tag.
interface issue_order_if #(
  parameter int ALU_OP_W = 5,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 6
);
  logic                valid;
  logic                ready;
  logic [ALU_OP_W-1:0] op;
  logic [DATA_W-1:0]   s1;
  logic [DATA_W-1:0]   s2;
  logic [TAG_W-1:0]    tag;

  modport master (output valid, op, s1, s2, tag, input ready);
  modport slave  (input valid, op, s1, s2, tag, output ready);
endinterface

// File: rtl/issue_order_ctrl.sv
// EX issue-slot ordering: squashes younger slots behind ld/st or branch, NOPs slot 0 after a
// forwarding stall, and steers M-ops in program order to one MUL/DIV via bypass or replay FIFO.
module issue_order_ctrl #(
  parameter int ISSUE_W      = 2,
  parameter int ALU_OP_W     = 5,
  parameter int DATA_W       = 32,
  parameter int TAG_W        = 6,
  parameter int ALU_MUL_BASE = 16,
  parameter int REPLAY_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [ISSUE_W-1:0]          id_valid,
  input  logic [ISSUE_W*ALU_OP_W-1:0] id_aluop,
  input  logic [ISSUE_W*DATA_W-1:0]   id_s1,
  input  logic [ISSUE_W*DATA_W-1:0]   id_s2,
  input  logic [ISSUE_W*TAG_W-1:0]    id_tag,
  input  logic [ISSUE_W-1:0]          ldst_flag,
  input  logic [ISSUE_W-1:0]          branch_flag,
  input  logic                        exforward_stall,
  output logic [ISSUE_W*ALU_OP_W-1:0] alu_op,
  output logic                        issue_stall,
  issue_order_if.master               m
);

  localparam int PTR_W = (REPLAY_DEPTH > 1) ? $clog2(REPLAY_DEPTH) : 1;
  localparam int CNT_W = $clog2(REPLAY_DEPTH + 1);
  localparam int SEL_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam logic [CNT_W-1:0]    STALL_TH = CNT_W'(REPLAY_DEPTH - ISSUE_W);
  localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(REPLAY_DEPTH);
  localparam logic [ALU_OP_W-1:0] MUL_BASE = ALU_OP_W'(ALU_MUL_BASE);

  logic [ALU_OP_W-1:0] mem_op  [REPLAY_DEPTH];
  logic [DATA_W-1:0]   mem_s1  [REPLAY_DEPTH];
  logic [DATA_W-1:0]   mem_s2  [REPLAY_DEPTH];
  logic [TAG_W-1:0]    mem_tag [REPLAY_DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_next, n_push;
  logic [CNT_W-1:0] push_ofs [ISSUE_W];
  logic [ISSUE_W-1:0] live, mop, push_en;
  logic [SEL_W-1:0] sel;
  logic nop_q, acc, blocked, empty, bypass, pop;

  assign issue_stall = (count > STALL_TH);
  assign empty       = (count == '0);
  assign acc         = ~issue_stall & ~flush & ~rst;

  // Slot squash and ALU lane steering; kill propagates only from slots that are themselves live.
  always_comb begin
    live    = '0;
    mop     = '0;
    alu_op  = '0;
    blocked = 1'b0;
    for (int k = 0; k < ISSUE_W; k++) begin
      live[k] = id_valid[k] & acc & ~blocked & ~((k == 0) & nop_q);
      mop[k]  = live[k] & (id_aluop[k*ALU_OP_W +: ALU_OP_W] >= MUL_BASE);
      if (live[k] && !mop[k]) begin
        alu_op[k*ALU_OP_W +: ALU_OP_W] = id_aluop[k*ALU_OP_W +: ALU_OP_W];
      end
      blocked = blocked | (live[k] & (ldst_flag[k] | branch_flag[k]));
    end
  end

  // The oldest live M-op may bypass only when nothing older is queued.
  always_comb begin
    sel     = '0;
    n_push  = '0;
    push_en = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      push_ofs[k] = '0;
    end
    for (int k = ISSUE_W - 1; k >= 0; k--) begin
      if (mop[k]) begin
        sel = SEL_W'(k);
      end
    end
    bypass = empty & m.ready & (|mop);
    for (int k = 0; k < ISSUE_W; k++) begin
      if (mop[k] && !(bypass && (sel == SEL_W'(k)))) begin
        push_en[k]  = 1'b1;
        push_ofs[k] = n_push;
        n_push      = n_push + CNT_W'(1);
      end
    end
  end

  always_comb begin
    m.valid = ~rst & ~flush & (~empty | bypass);
    m.op    = mem_op[rd_ptr];
    m.s1    = mem_s1[rd_ptr];
    m.s2    = mem_s2[rd_ptr];
    m.tag   = mem_tag[rd_ptr];
    if (empty) begin
      m.op  = id_aluop[sel*ALU_OP_W +: ALU_OP_W];
      m.s1  = id_s1[sel*DATA_W +: DATA_W];
      m.s2  = id_s2[sel*DATA_W +: DATA_W];
      m.tag = id_tag[sel*TAG_W +: TAG_W];
    end
  end

  assign pop        = m.valid & m.ready & ~empty;
  assign count_next = count - CNT_W'(pop) + n_push;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      nop_q  <= 1'b0;
    end else begin
      count  <= count_next;
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      nop_q  <= exforward_stall;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < ISSUE_W; k++) begin
      if (push_en[k]) begin
        mem_op [wr_ptr + PTR_W'(push_ofs[k])] <= id_aluop[k*ALU_OP_W +: ALU_OP_W];
        mem_s1 [wr_ptr + PTR_W'(push_ofs[k])] <= id_s1[k*DATA_W +: DATA_W];
        mem_s2 [wr_ptr + PTR_W'(push_ofs[k])] <= id_s2[k*DATA_W +: DATA_W];
        mem_tag[wr_ptr + PTR_W'(push_ofs[k])] <= id_tag[k*TAG_W +: TAG_W];
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);

endmodule
